// File: rtl/sprite_render_pipe.sv
// Purpose: sprite pixel lookup pipeline plus IDLE/WALK/ATTACK animation FSM selecting the sprite ROM.
// Latency: 3 cycles from draw_x/draw_y to sprite_on/sprite_idx, one pixel per cycle; rom_sel updates the cycle after frame_tick.
// Backpressure: none; the pipeline free-runs with the pixel clock and every input is sampled each cycle.
//
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   draw_x, draw_y            : current raster pixel
//   pos_x, pos_y              : sprite top-left corner
//   dir, moving               : facing (0 down, 1 up, 2 left, 3 right) and walking level
//   attack_req, frame_tick    : swing request pulse, once-per-frame pulse in vertical blank
//   rom_q / rom_addr, rom_sel : sprite ROM data (1-cycle synchronous read), address and image select
//   sprite_on, sprite_idx     : opaque sprite pixel present and its palette index
//   attack_busy               : high while the sword swing is playing
module sprite_render_pipe (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [1:0] dir,
  input  logic       moving,
  input  logic       attack_req,
  input  logic       frame_tick,
  input  logic [2:0] rom_q,
  output logic [9:0] rom_addr,
  output logic [4:0] rom_sel,
  output logic       sprite_on,
  output logic [2:0] sprite_idx,
  output logic       attack_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, ATTACK = 2'd2} state_t;

  // ---------------------------------------------------------------- pixel pipe
  // Bounds are compared at 11 bits so a sprite near column/row 1023 does not
  // wrap its right/bottom edge back to small coordinates.
  logic [10:0] x_end, y_end;
  logic [9:0]  off_x, off_y;
  logic        in_box;
  logic        inbox_d1, inbox_d2;
  logic        opaque;

  assign x_end  = {1'b0, pos_x} + 11'd32;
  assign y_end  = {1'b0, pos_y} + 11'd32;
  assign off_x  = draw_x - pos_x;
  assign off_y  = draw_y - pos_y;
  assign in_box = ({1'b0, draw_x} >= {1'b0, pos_x}) && ({1'b0, draw_x} < x_end) &&
                  ({1'b0, draw_y} >= {1'b0, pos_y}) && ({1'b0, draw_y} < y_end);
  assign opaque = inbox_d2 && (rom_q != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr   <= '0;
      inbox_d1   <= 1'b0;
      inbox_d2   <= 1'b0;
      sprite_on  <= 1'b0;
      sprite_idx <= '0;
    end else begin
      rom_addr   <= in_box ? {off_y[4:0], off_x[4:0]} : 10'd0;
      inbox_d1   <= in_box;
      inbox_d2   <= inbox_d1;  // lines up with rom_q of the same pixel
      sprite_on  <= opaque;
      sprite_idx <= opaque ? rom_q : 3'd0;
    end
  end

  // ---------------------------------------------------------------- animation FSM
  state_t     state, state_nxt;
  logic       pending, pending_nxt;
  logic [2:0] walk_cnt, walk_cnt_nxt;
  logic       walk_frame, walk_frame_nxt;
  logic [1:0] sword_frame, sword_frame_nxt;
  logic [1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0] atk_dir, atk_dir_nxt;
  logic [4:0] rom_sel_nxt;

  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    walk_cnt_nxt    = walk_cnt;
    walk_frame_nxt  = walk_frame;
    sword_frame_nxt = sword_frame;
    hold_cnt_nxt    = hold_cnt;
    atk_dir_nxt     = atk_dir;

    // A request seen on a tick cycle is only latched here; the transition
    // below looks at the old pending value, so it acts on the next tick.
    if (attack_req && state != ATTACK)
      pending_nxt = 1'b1;

    if (frame_tick) begin
      case (state)
        IDLE, WALK: begin
          if (pending) begin
            state_nxt       = ATTACK;
            pending_nxt     = 1'b0;
            sword_frame_nxt = 2'd0;
            hold_cnt_nxt    = 2'd0;
            atk_dir_nxt     = dir;
          end else if (state == IDLE) begin
            if (moving)
              state_nxt = WALK;
          end else if (!moving) begin
            state_nxt      = IDLE;
            walk_cnt_nxt   = 3'd0;
            walk_frame_nxt = 1'b0;
          end else begin
            walk_cnt_nxt = walk_cnt + 3'd1;
            if (walk_cnt == 3'd7)
              walk_frame_nxt = ~walk_frame;
          end
        end
        ATTACK: begin
          hold_cnt_nxt = hold_cnt + 2'd1;
          if (hold_cnt == 2'd3) begin
            sword_frame_nxt = sword_frame + 2'd1;
            if (sword_frame == 2'd3) begin
              if (moving) begin
                state_nxt = WALK;
              end else begin
                state_nxt      = IDLE;
                walk_cnt_nxt   = 3'd0;
                walk_frame_nxt = 1'b0;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Image select for the post-tick state: 0..7 walk/idle, 8..23 sword.
    if (state_nxt == ATTACK)
      rom_sel_nxt = {1'b0, atk_dir_nxt, sword_frame_nxt} + 5'd8;
    else
      rom_sel_nxt = {2'b00, dir, walk_frame_nxt};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      walk_cnt    <= '0;
      walk_frame  <= 1'b0;
      sword_frame <= '0;
      hold_cnt    <= '0;
      atk_dir     <= '0;
      rom_sel     <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      walk_cnt    <= walk_cnt_nxt;
      walk_frame  <= walk_frame_nxt;
      sword_frame <= sword_frame_nxt;
      hold_cnt    <= hold_cnt_nxt;
      atk_dir     <= atk_dir_nxt;
      // Only refreshed at the frame boundary so the image never changes mid-frame.
      if (frame_tick)
        rom_sel <= rom_sel_nxt;
    end
  end

  assign attack_busy = (state == ATTACK);

endmodule

// File: tb/tb_sprite_render_pipe.sv
// Purpose: self-checking bench for sprite_render_pipe (pixel pipeline and animation FSM).
// Latency: pixel expectations are checked 1 cycle (rom_addr) and 3 cycles (sprite_on/idx) after drive.
// Backpressure: none; inputs are driven and outputs sampled on the falling clock edge.
module tb_sprite_render_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, attack_req, frame_tick;
  logic [2:0] rom_q;
  logic [9:0] rom_addr;
  logic [4:0] rom_sel;
  logic       sprite_on;
  logic [2:0] sprite_idx;
  logic       attack_busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sprite_render_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .moving     (moving),
    .attack_req (attack_req),
    .frame_tick (frame_tick),
    .rom_q      (rom_q),
    .rom_addr   (rom_addr),
    .rom_sel    (rom_sel),
    .sprite_on  (sprite_on),
    .sprite_idx (sprite_idx),
    .attack_busy(attack_busy)
  );

  // Sprite ROM contents; the bench plays the synchronous ROM.
  logic [2:0] mem [0:1023];

  localparam int NPIX = 400;
  localparam int NDIR = 8;
  int ea   [NPIX];
  int eidx [NPIX];
  int dpx [NDIR] = '{100, 100, 100, 1000, 100, 100, 100, 1000};
  int dpy [NDIR] = '{50,  50,  50,  0,    50,  50,  50,  1000};
  int ddx [NDIR] = '{105, 132, 99,  5,    103, 131, 100, 1023};
  int ddy [NDIR] = '{53,  50,  50,  0,    55,  81,  82,  1023};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: a pixel is covered when it lies in the 32x32 square whose
  // corner is (px,py), using unbounded integer arithmetic.
  function automatic void model_px(input int px, input int py, input int dx, input int dy,
                                   output int addr, output int idx);
    bit hit;
    hit  = (dx >= px) && (dx < px + 32) && (dy >= py) && (dy < py + 32);
    addr = hit ? (dy - py) * 32 + (dx - px) : 0;
    idx  = hit ? int'(mem[addr]) : 0;
  endfunction

  task automatic tick(input bit req);
    @(negedge clock);
    frame_tick = 1'b1;
    attack_req = req;
    @(negedge clock);
    frame_tick = 1'b0;
    attack_req = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_req();
    @(negedge clock);
    attack_req = 1'b1;
    @(negedge clock);
    attack_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int px, py, dx, dy, a, ix, prev_addr, d, d2, sel0;

    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    mem[0]      = 3'd3;
    mem[10'h065] = 3'd5;
    mem[10'h0A3] = 3'd0;
    mem[10'h3FF] = 3'd7;

    // Reset with busy-looking inputs: in-box pixel, opaque data, requests and ticks.
    reset = 1'b1;
    pos_x = 10'd100; pos_y = 10'd50; draw_x = 10'd105; draw_y = 10'd53;
    dir = 2'd3; moving = 1'b1; attack_req = 1'b1; frame_tick = 1'b1; rom_q = 3'd5;
    gap(4);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_sel", rom_sel, 0);
    chk("rst_sprite_on", sprite_on, 0);
    chk("rst_sprite_idx", sprite_idx, 0);
    chk("rst_attack_busy", attack_busy, 0);
    attack_req = 1'b0; frame_tick = 1'b0; moving = 1'b0;

    // Pixel pipeline: directed corner cases first, then random pixels near the box.
    prev_addr = 0;
    for (int n = 0; n < NPIX; n++) begin
      @(negedge clock);
      if (n == 0) reset = 1'b0;
      if (n >= 1) chk("rom_addr", rom_addr, ea[n-1]);
      if (n == 1 || n == 2) begin
        chk("flush_on", sprite_on, 0);
        chk("flush_idx", sprite_idx, 0);
      end
      if (n >= 3) begin
        chk("sprite_on", sprite_on, (eidx[n-3] != 0) ? 1 : 0);
        chk("sprite_idx", sprite_idx, eidx[n-3]);
      end
      rom_q     = mem[prev_addr];
      prev_addr = int'(rom_addr);
      if (n < NDIR) begin
        px = dpx[n]; py = dpy[n]; dx = ddx[n]; dy = ddy[n];
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
        dx = (px + int'($urandom_range(0, 39)) - 4 + 1024) % 1024;
        dy = (py + int'($urandom_range(0, 39)) - 4 + 1024) % 1024;
      end
      pos_x = 10'(px); pos_y = 10'(py); draw_x = 10'(dx); draw_y = 10'(dy);
      model_px(px, py, dx, dy, a, ix);
      ea[n]   = a;
      eidx[n] = ix;
    end

    // Park on an opaque in-box pixel for the FSM part.
    pos_x = 10'd100; pos_y = 10'd50; draw_x = 10'd100; draw_y = 10'd50; rom_q = 3'd3;
    gap(4);
    chk("park_on", sprite_on, 1);
    chk("park_idx", sprite_idx, 3);

    // First tick: request seen during reset must not start a swing.
    dir = 2'd3; moving = 1'b0;
    tick(1'b0);
    chk("idle_busy", attack_busy, 0);
    chk("idle_sel", rom_sel, 6);

    // Walking right: frame toggles every 8 ticks counting the entry tick.
    moving = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0);
      chk("walk_sel", rom_sel, 6 + (((k - 1) >> 3) & 1));
      chk("walk_busy", attack_busy, 0);
      if (k == 5) begin
        dir = 2'd0;
        gap(2);
        chk("sel_stable", rom_sel, 6);
        dir = 2'd3;
      end
      gap($urandom_range(0, 2));
    end
    moving = 1'b0;
    tick(1'b0);
    chk("walk_stop_sel", rom_sel, 6);
    chk("walk_stop_busy", attack_busy, 0);

    // Re-entering WALK must start the walk counter from zero.
    moving = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0);
      chk("rewalk_sel", rom_sel, (k == 9) ? 7 : 6);
    end
    moving = 1'b0;
    tick(1'b0);
    chk("rewalk_stop_sel", rom_sel, 6);

    // Sword swing facing left: 4 frames of 4 ticks; extra request mid-swing ignored.
    dir = 2'd2;
    pulse_req();
    gap(2);
    chk("req_no_tick_busy", attack_busy, 0);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      chk("atk_sel", rom_sel, 16 + (k - 1) / 4);
      chk("atk_busy", attack_busy, 1);
      if (k == 3) dir = 2'd1;
      if (k == 7) dir = 2'd2;
      if (k == 8) pulse_req();
      gap($urandom_range(0, 2));
    end
    tick(1'b0);
    chk("atk_end_sel", rom_sel, 4);
    chk("atk_end_busy", attack_busy, 0);
    tick(1'b0);
    chk("atk_discard_busy", attack_busy, 0);
    chk("atk_discard_sel", rom_sel, 4);

    // Request coinciding with a tick acts one tick later.
    d = int'($urandom_range(0, 3));
    dir = 2'(d);
    sel0 = 8 + d * 4;
    tick(1'b1);
    chk("coinc_busy0", attack_busy, 0);
    tick(1'b0);
    chk("coinc_busy1", attack_busy, 1);
    chk("coinc_sel", rom_sel, sel0);
    repeat (8) tick(1'b0);
    chk("sf2_sel", rom_sel, sel0 + 2);
    chk("sf2_on", sprite_on, 1);

    // Reset mid-swing aborts everything.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", attack_busy, 0);
    chk("abort_sel", rom_sel, 0);
    chk("abort_on", sprite_on, 0);
    chk("abort_idx", sprite_idx, 0);
    tick(1'b0);
    chk("abort_tick_busy", attack_busy, 0);
    chk("abort_tick_sel", rom_sel, d * 2);

    // Swing finishing while moving goes to WALK.
    d2 = int'($urandom_range(0, 3));
    dir = 2'(d2);
    moving = 1'b1;
    pulse_req();
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      chk("atk2_sel", rom_sel, 8 + d2 * 4 + (k - 1) / 4);
    end
    tick(1'b0);
    chk("atk2_end_busy", attack_busy, 0);
    chk("atk2_end_sel", rom_sel, d2 * 2);
    tick(1'b0);
    chk("atk2_walk_sel", rom_sel, d2 * 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_render_pipe.md
SPRITE_RENDER_PIPE -- requirements
Module: sprite_render_pipe

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port draw_x, input, 10: current VGA pixel column.
REQ-004 SHALL have port draw_y, input, 10: current VGA pixel row.
REQ-005 SHALL have port pos_x, input, 10: sprite top-left column.
REQ-006 SHALL have port pos_y, input, 10: sprite top-left row.
REQ-007 SHALL have port dir, input, 2: facing; 0 down, 1 up, 2 left, 3 right.
REQ-008 SHALL have port moving, input, 1: level; player is walking.
REQ-009 SHALL have port attack_req, input, 1: one-cycle pulse requesting a sword swing.
REQ-010 SHALL have port frame_tick, input, 1: one-cycle pulse, once per frame, during vertical blank.
REQ-011 SHALL have port rom_q, input, 3: palette index from the selected sprite ROM; 1-cycle synchronous read.
REQ-012 SHALL have port rom_addr, output, 10: sprite ROM address.
REQ-013 SHALL have port rom_sel, output, 5: sprite ROM select.
REQ-014 SHALL have port sprite_on, output, 1: opaque sprite pixel present.
REQ-015 SHALL have port sprite_idx, output, 3: palette index of that pixel.
REQ-016 SHALL have port attack_busy, output, 1: high while in ATTACK.

Function
REQ-017 SHALL treat a pixel as in-box when pos_x <= draw_x < pos_x+32 and pos_y <= draw_y < pos_y+32, with the compares done at 11 bits so there is no wrap at 1023.
REQ-018 SHALL register rom_addr = {draw_y-pos_y [4:0], draw_x-pos_x [4:0]} when in-box, and 0 otherwise; this is pipeline stage 1.
REQ-019 SHALL delay the in-box flag two cycles to align it with rom_q.
REQ-020 SHALL register sprite_idx = rom_q and sprite_on = (delayed in-box AND rom_q != 0); index 0 is transparent, and sprite_idx SHALL be 0 when sprite_on is 0.
REQ-021 SHALL have a total latency of 3 cycles from draw_x/draw_y to sprite_on/sprite_idx, fully pipelined at 1 pixel per cycle.
REQ-022 SHALL implement the FSM states IDLE, WALK, ATTACK; transitions occur only on frame_tick cycles.
REQ-023 IDLE->WALK SHALL occur when moving=1; WALK->IDLE SHALL occur when moving=0.
REQ-024 An attack_req pulse on any cycle SHALL set attack_pending; pulses received while in ATTACK SHALL be discarded.
REQ-025 At a frame_tick with attack_pending=1 in IDLE or WALK, the FSM SHALL enter ATTACK, clear pending, set sword_frame=0 and hold_cnt=0, and latch dir into atk_dir.
REQ-026 In ATTACK, each frame_tick SHALL increment the 2-bit hold_cnt; on wrap 3->0, sword_frame SHALL increment.
REQ-027 When sword_frame=3 and hold_cnt wraps, the FSM SHALL leave ATTACK (16 ticks total) to WALK if moving=1, else to IDLE.
REQ-028 If attack_req and frame_tick coincide, the request SHALL be latched and take effect at the next frame_tick.
REQ-029 In WALK, the 3-bit walk_cnt SHALL increment per frame_tick and walk_frame SHALL toggle on the wrap 7->0; entering IDLE SHALL clear walk_cnt and walk_frame.
REQ-030 rom_sel SHALL be {dir, walk_frame} (values 0..7) in IDLE/WALK and 8 + atk_dir*4 + sword_frame (values 8..23) in ATTACK.
REQ-031 rom_sel SHALL be registered and change only on the cycle after frame_tick, so it is stable across all visible lines.
REQ-032 attack_busy SHALL be high exactly while the state is ATTACK.

Reset
REQ-033 reset=1 SHALL force: state IDLE; attack_pending, walk_cnt, walk_frame, sword_frame, hold_cnt, atk_dir = 0; rom_addr, rom_sel, sprite_on, sprite_idx, attack_busy = 0; all pipeline valid flags = 0.
REQ-034 Reset asserted mid-ATTACK SHALL abort the attack; the first post-reset output SHALL be computed from fresh inputs only.

Verification
REQ-035 pos=(100,50), draw=(105,53), rom_q=5 two cycles later -> rom_addr=0x065 at t+1; sprite_on=1 and sprite_idx=5 at t+3.
REQ-036 pos=(100,50), draw=(132,50) and draw=(99,50) -> rom_addr=0, sprite_on=0; with pos_x=1000, draw_x=5 -> no false hit.
REQ-037 In-box pixel with rom_q=0 -> sprite_on=0, sprite_idx=0.
REQ-038 dir=3, moving=1, 16 frame_ticks -> rom_sel sequence 6 (ticks 1-8 after entering WALK), 7, 6; on moving=0 at a tick -> rom_sel=6, state IDLE.
REQ-039 dir=2, attack_req, then 17 frame_ticks -> rom_sel 16,17,18,19 (4 ticks each), attack_busy high for 16 ticks, then rom_sel=4; a second attack_req mid-swing has no effect.
REQ-040 reset pulse during ATTACK at sword_frame=2 -> next cycle attack_busy=0, rom_sel=0, sprite_on=0.
